// File: rtl/linear_layer_start_fifo_srl_if.sv
// Start-token FIFO handshake bundle: write side (push) and read side (pop).
// master = token producer/consumer side, slave = the FIFO itself.
interface linear_layer_start_fifo_srl_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;

    modport master (
        output if_write_ce, if_write, if_din,
        output if_read_ce, if_read,
        input  if_full_n, if_dout, if_empty_n
    );

    modport slave (
        input  if_write_ce, if_write, if_din,
        input  if_read_ce, if_read,
        output if_full_n, if_dout, if_empty_n
    );
endinterface

// File: rtl/linear_layer_start_fifo_srl.sv
// SRL-style start-token FIFO: shift-in storage, addressed read, registered flags.
// Optional macro START_FIFO_PROT_CHK_EN adds sticky err_ovf/err_udf outputs.

module linear_layer_start_fifo_srl_shiftreg #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_dout
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // New token enters at entry 0; older tokens move one slot deeper.
    always_ff @(posedge clk) begin
        if (i_shift) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    // Addressed read; out-of-range address (empty) yields zero.
    always_comb begin
        o_dout = '0;
        if (int'(i_addr) < DEPTH) begin
            o_dout = r_mem[i_addr];
        end
    end
endmodule

module linear_layer_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic clk,
    input  logic reset,
    linear_layer_start_fifo_srl_if.slave bus
`ifdef START_FIFO_PROT_CHK_EN
    ,
    output logic err_ovf,
    output logic err_udf
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_full_n;
    logic                  w_empty_n;

    assign w_full_n  = (r_state != S_FULL);
    assign w_empty_n = (r_state != S_EMPTY);
    assign w_wr = bus.if_write_ce & bus.if_write & w_full_n;
    assign w_rd = bus.if_read_ce & bus.if_read & w_empty_n;

    assign bus.if_full_n  = w_full_n;
    assign bus.if_empty_n = w_empty_n;

    linear_layer_start_fifo_srl_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_shift (w_wr & ~reset),
        .i_din   (bus.if_din),
        .i_addr  (r_addr),
        .o_dout  (bus.if_dout)
    );

    // Occupancy state, count and read address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_cnt   <= '0;
            r_addr  <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Push-only grows, pop-only shrinks; push+pop keeps occupancy.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        case ({w_wr, w_rd})
            2'b10: begin
                w_cnt_nxt   = r_cnt + LP_ONE;
                w_addr_nxt  = r_addr + 1'b1;
                w_state_nxt = (r_cnt + LP_ONE == LP_DEPTH) ? S_FULL : S_PART;
            end
            2'b01: begin
                w_cnt_nxt   = r_cnt - LP_ONE;
                w_addr_nxt  = r_addr - 1'b1;
                w_state_nxt = (r_cnt == LP_ONE) ? S_EMPTY : S_PART;
            end
            default: ;
        endcase
    end

`ifdef START_FIFO_PROT_CHK_EN
    logic w_ovf_evt;
    logic w_udf_evt;
    logic r_err_ovf;
    logic r_err_udf;

    assign w_ovf_evt = bus.if_write_ce & bus.if_write & ~w_full_n;
    assign w_udf_evt = bus.if_read_ce & bus.if_read & ~w_empty_n;
    assign err_ovf   = r_err_ovf;
    assign err_udf   = r_err_udf;

    // Sticky protocol-violation flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_ovf_evt) r_err_ovf <= 1'b1;
            if (w_udf_evt) r_err_udf <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only report of each violation.
    always_ff @(posedge clk) begin
        if (!reset && w_ovf_evt) $error("start fifo overflow push");
        if (!reset && w_udf_evt) $error("start fifo underflow pop");
    end
`endif
`endif
endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Self-checking bench for linear_layer_start_fifo_srl (DEPTH=2).
// Directed vector table, push+pop streaming sequence, randomized model check.
module tb_linear_layer_start_fifo_srl;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_err = 0;
    int   n_chk = 0;
    bit   q[$];

    linear_layer_start_fifo_srl_if #(.DATA_WIDTH(1)) bus ();

`ifdef START_FIFO_PROT_CHK_EN
    logic err_ovf;
    logic err_udf;
`endif

    linear_layer_start_fifo_srl #(
        .DATA_WIDTH (1),
        .ADDR_WIDTH (1),
        .DEPTH      (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef START_FIFO_PROT_CHK_EN
        ,
        .err_ovf (err_ovf),
        .err_udf (err_udf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, wce, w, din, rce, r;
        bit e_empty_n, e_full_n, e_dout;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Apply inputs for one cycle, advance the queue model, sample after edge.
    task automatic cyc(input bit rst, input bit wce, input bit w,
                       input bit din, input bit rce, input bit r);
        bit acc_w, acc_r;
        reset           = rst;
        bus.if_write_ce = wce;
        bus.if_write    = w;
        bus.if_din      = din;
        bus.if_read_ce  = rce;
        bus.if_read     = r;
        acc_w = wce && w && (q.size() < DEPTH);
        acc_r = rce && r && (q.size() > 0);
        @(posedge clk);
        if (rst) q.delete();
        else begin
            if (acc_r) void'(q.pop_front());
            if (acc_w) q.push_back(din);
        end
        #1;
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".empty_n"}, int'(bus.if_empty_n), int'(q.size() > 0));
        chk({nm, ".full_n"}, int'(bus.if_full_n), int'(q.size() < DEPTH));
        if (q.size() > 0) chk({nm, ".dout"}, int'(bus.if_dout), int'(q[0]));
    endtask

    task automatic add(input bit rst, wce, w, din, rce, r, ee, ef, ed);
        vec_t v;
        v.rst = rst; v.wce = wce; v.w = w; v.din = din;
        v.rce = rce; v.r = r;
        v.e_empty_n = ee; v.e_full_n = ef; v.e_dout = ed;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        bus.if_write_ce = 0; bus.if_write = 0; bus.if_din = 0;
        bus.if_read_ce = 0;  bus.if_read = 0;

        //  rst wce w din rce r | empty_n full_n dout
        add(1, 1, 1, 1, 0, 0,   0, 1, 0);
        add(1, 1, 1, 1, 0, 0,   0, 1, 0);
        add(1, 1, 1, 1, 0, 0,   0, 1, 0);
        add(0, 1, 1, 1, 0, 0,   1, 1, 1);
        add(0, 1, 1, 0, 0, 0,   1, 0, 1);
        add(0, 1, 1, 1, 0, 0,   1, 0, 1);
        add(0, 0, 0, 0, 1, 1,   1, 1, 0);
        add(0, 0, 0, 0, 1, 1,   0, 1, 0);
        add(0, 0, 0, 0, 1, 1,   0, 1, 0);
        add(0, 1, 1, 1, 1, 1,   1, 1, 1);
        add(0, 0, 0, 0, 1, 1,   0, 1, 0);
        add(0, 1, 1, 1, 0, 0,   1, 1, 1);
        add(0, 1, 1, 0, 0, 0,   1, 0, 1);
        add(1, 0, 0, 0, 1, 1,   0, 1, 0);
        add(0, 1, 1, 1, 0, 0,   1, 1, 1);
        add(0, 1, 1, 0, 0, 0,   1, 0, 1);
        add(0, 1, 1, 0, 1, 1,   1, 1, 0);
        add(0, 0, 1, 1, 1, 1,   0, 1, 0);
        add(0, 1, 1, 1, 0, 1,   1, 1, 1);
        add(0, 0, 0, 0, 1, 0,   1, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].wce, tbl[i].w, tbl[i].din,
                tbl[i].rce, tbl[i].r);
            chk($sformatf("vec%0d.empty_n", i),
                int'(bus.if_empty_n), int'(tbl[i].e_empty_n));
            chk($sformatf("vec%0d.full_n", i),
                int'(bus.if_full_n), int'(tbl[i].e_full_n));
            if (tbl[i].e_empty_n)
                chk($sformatf("vec%0d.dout", i),
                    int'(bus.if_dout), int'(tbl[i].e_dout));
        end

        // Streaming at occupancy 1: head is always the previous push.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            bit d;
            d = bit'(i % 2);
            cyc(0, 1, 1, d, 1, 1);
            chk($sformatf("stream%0d.empty_n", i), int'(bus.if_empty_n), 1);
            chk($sformatf("stream%0d.full_n", i), int'(bus.if_full_n), 1);
            chk($sformatf("stream%0d.dout", i), int'(bus.if_dout), int'(d));
        end
        cyc(0, 0, 0, 0, 1, 1);
        chk("stream_drain.empty_n", int'(bus.if_empty_n), 0);

`ifdef START_FIFO_PROT_CHK_EN
        cyc(1, 0, 0, 0, 0, 0);
        chk("err_rst.ovf", int'(err_ovf), 0);
        chk("err_rst.udf", int'(err_udf), 0);
        cyc(0, 0, 0, 0, 1, 1);
        chk("err_udf", int'(err_udf), 1);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        chk("err_ovf", int'(err_ovf), 1);
        cyc(0, 0, 0, 0, 1, 1);
        chk("err_ovf.sticky", int'(err_ovf), 1);
        chk("err_udf.sticky", int'(err_udf), 1);
`endif

        // Randomized traffic against the queue model.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            cyc(bit'($urandom_range(0, 39) == 0),
                bit'($urandom_range(0, 3) != 0), bit'($urandom),
                bit'($urandom),
                bit'($urandom_range(0, 3) != 0), bit'($urandom));
            chk_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
